ah_encoder_8_12: RTL and testbench

Egress-side counterpart of the 12-bit, 8-client address decoder. Up to 8 clients raise requests, each with a local offset. The block arbitrates round-robin and encodes the winner into a 12-bit packet field as {client_id[2:0], offset[8:0]}. The field is presented on a registered valid/ready egress port that feeds the fabric, whose decoder maps the field back to the same client.

---
 rtl/ah_encoder_8_12.sv | 145 ++++++++++++++
 tb/tb_ah_encoder_8_12.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ah_encoder_8_12.sv
//------------------------------------------------------------------------------
// Module      : ah_encoder_8_12
// Description : Round-robin arbiter for 8 clients that encodes the winner as
//               {client_id, offset} onto a registered valid/ready egress port.
//               Optional build macro AH_ENCODER_CNT_EN adds pkt_cnt/err_cnt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ah_encoder_8_12 #(
    parameter int NUM_CLIENTS = 8,
    parameter int FIELD_W     = 12,
    parameter int OFFS_W      = 9,
    parameter int OFFS_MAX    = 511
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS*OFFS_W-1:0] client_offset,
    output logic [NUM_CLIENTS-1:0]        client_gnt,
    output logic [FIELD_W-1:0]            egress_pkt_field,
    output logic                          egress_valid,
    input  logic                          egress_ready,
    output logic                          enc_err
`ifdef AH_ENCODER_CNT_EN
    ,
    output logic [15:0]                   pkt_cnt,
    output logic [7:0]                    err_cnt
`endif
);

    localparam int ID_W = FIELD_W - OFFS_W;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      last_gnt_q;
    logic [FIELD_W-1:0]   field_q;
    logic                 enc_err_q;

    logic                 w_any_req;
    logic                 w_can_load;
    logic                 w_grant;
    logic                 w_found;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      w_win_idx;
    logic [OFFS_W-1:0]    w_win_off;
    logic                 w_off_err;
    logic [FIELD_W-1:0]   field_d;

    assign w_any_req  = |client_req;
    assign w_can_load = (state_q == ST_EMPTY) || egress_ready;
    assign w_grant    = w_any_req && w_can_load && !rst;

    // Search starts one past the last winner and wraps, giving rotating priority.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            w_idx = last_gnt_q + ID_W'(k);
            if (!w_found && client_req[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    assign w_win_off = client_offset[32'(w_win_idx) * OFFS_W +: OFFS_W];
    assign w_off_err = 32'(w_win_off) > 32'(OFFS_MAX);
    assign field_d   = {w_win_idx, w_win_off};

    always_comb begin
        client_gnt = '0;
        if (w_grant) begin
            client_gnt[w_win_idx] = 1'b1;
        end
    end

    // A bad offset still consumes the grant but leaves the output register as
    // if no request had been present.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            field_q    <= '0;
            enc_err_q  <= 1'b0;
            last_gnt_q <= ID_W'(NUM_CLIENTS - 1);
        end else begin
            enc_err_q <= w_grant && w_off_err;
            if (w_grant) begin
                last_gnt_q <= w_win_idx;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (w_grant && !w_off_err) begin
                        field_q <= field_d;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (egress_ready) begin
                        if (w_grant && !w_off_err) begin
                            field_q <= field_d;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign egress_valid     = (state_q == ST_FULL);
    assign egress_pkt_field = field_q;
    assign enc_err          = enc_err_q;

`ifdef AH_ENCODER_CNT_EN
    logic [15:0] pkt_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (egress_valid && egress_ready) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (enc_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ah_encoder_8_12.sv
//------------------------------------------------------------------------------
// Module      : tb_ah_encoder_8_12
// Description : Directed self-checking bench for ah_encoder_8_12 (default and
//               OFFS_MAX=100 instances driven from the same stimulus).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ah_encoder_8_12;

    logic        clk;
    logic        rst;
    logic [7:0]  client_req;
    logic [71:0] client_offset;
    logic        egress_ready;

    logic [7:0]  gnt_a, gnt_e;
    logic [11:0] field_a, field_e;
    logic        valid_a, valid_e;
    logic        err_a, err_e;
`ifdef AH_ENCODER_CNT_EN
    logic [15:0] pkt_cnt_a, pkt_cnt_e;
    logic [7:0]  err_cnt_a, err_cnt_e;
`endif

    int n_vec = 0;
    int n_err = 0;

    ah_encoder_8_12 dut (
        .clk              (clk),
        .rst              (rst),
        .client_req       (client_req),
        .client_offset    (client_offset),
        .client_gnt       (gnt_a),
        .egress_pkt_field (field_a),
        .egress_valid     (valid_a),
        .egress_ready     (egress_ready),
        .enc_err          (err_a)
`ifdef AH_ENCODER_CNT_EN
        ,
        .pkt_cnt          (pkt_cnt_a),
        .err_cnt          (err_cnt_a)
`endif
    );

    ah_encoder_8_12 #(.OFFS_MAX(100)) dut_e (
        .clk              (clk),
        .rst              (rst),
        .client_req       (client_req),
        .client_offset    (client_offset),
        .client_gnt       (gnt_e),
        .egress_pkt_field (field_e),
        .egress_valid     (valid_e),
        .egress_ready     (egress_ready),
        .enc_err          (err_e)
`ifdef AH_ENCODER_CNT_EN
        ,
        .pkt_cnt          (pkt_cnt_e),
        .err_cnt          (err_cnt_e)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_off(input int i, input logic [8:0] v);
        client_offset[i*9 +: 9] = v;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        client_req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        client_req    = 8'hFF;
        client_offset = '0;
        egress_ready  = 1'b1;
        tick();
        tick();
        n_vec++;
        if (gnt_a !== 8'h00) begin
            n_err++; $display("FAIL reset_gnt: got %h want 00", gnt_a);
        end
        n_vec++;
        if ({valid_a, field_a, err_a} !== 14'h0) begin
            n_err++; $display("FAIL reset_out: got v=%b f=%h e=%b want 0/000/0", valid_a, field_a, err_a);
        end
`ifdef AH_ENCODER_CNT_EN
        n_vec++;
        if ({pkt_cnt_a, err_cnt_a} !== 24'h0) begin
            n_err++; $display("FAIL reset_cnt: got pkt=%0d err=%0d want 0/0", pkt_cnt_a, err_cnt_a);
        end
`endif
        rst        = 1'b0;
        client_req = 8'h00;
        tick();
    endtask

    task automatic test_single();
        reset_dut();
        set_off(0, 9'h0AB);
        client_req   = 8'h01;
        egress_ready = 1'b1;
        #1;
        n_vec++;
        if (gnt_a !== 8'h01) begin
            n_err++; $display("FAIL single_gnt: got %h want 01", gnt_a);
        end
        tick();
        client_req = 8'h00;
        n_vec++;
        if (valid_a !== 1'b1 || field_a !== 12'h0AB) begin
            n_err++; $display("FAIL single_out: got v=%b f=%h want 1/0ab", valid_a, field_a);
        end
        tick();
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got v=%b want 0", valid_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_f;
        logic [7:0]  exp_g;
        reset_dut();
        for (int i = 0; i < 8; i++) set_off(i, 9'(9'h020 + 9'(i * 3)));
        client_req   = 8'hFF;
        egress_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            exp_g = 8'h01 << (c % 8);
            exp_f = {3'(c % 8), 9'(9'h020 + 9'((c % 8) * 3))};
            #1;
            n_vec++;
            if (gnt_a !== exp_g) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %h want %h", c, gnt_a, exp_g);
            end
            tick();
            n_vec++;
            if (valid_a !== 1'b1 || field_a !== exp_f) begin
                n_err++; $display("FAIL rr_field[%0d]: got v=%b f=%h want 1/%h", c, valid_a, field_a, exp_f);
            end
        end
        client_req = 8'h00;
        tick();
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL rr_drain: got v=%b want 0", valid_a);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        set_off(3, 9'h1FF);
        client_req   = 8'h08;
        egress_ready = 1'b0;
        #1;
        n_vec++;
        if (gnt_a !== 8'h08) begin
            n_err++; $display("FAIL bp_gnt: got %h want 08", gnt_a);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (valid_a !== 1'b1 || field_a !== 12'h7FF || gnt_a !== 8'h00) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b f=%h g=%h want 1/7ff/00", c, valid_a, field_a, gnt_a);
            end
            if (c == 0) client_req = 8'h00;
            tick();
        end
        egress_ready = 1'b1;
        #1;
        n_vec++;
        if (valid_a !== 1'b1 || field_a !== 12'h7FF) begin
            n_err++; $display("FAIL bp_accept: got v=%b f=%h want 1/7ff", valid_a, field_a);
        end
        tick();
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: got v=%b want 0", valid_a);
        end
    endtask

    task automatic test_enc_err();
        reset_dut();
        set_off(5, 9'd101);
        client_req   = 8'h20;
        egress_ready = 1'b1;
        #1;
        n_vec++;
        if (gnt_e !== 8'h20) begin
            n_err++; $display("FAIL err_gnt: got %h want 20", gnt_e);
        end
        tick();
        client_req = 8'h00;
        n_vec++;
        if (err_e !== 1'b1 || valid_e !== 1'b0) begin
            n_err++; $display("FAIL err_pulse: got e=%b v=%b want 1/0", err_e, valid_e);
        end
        n_vec++;
        if (err_a !== 1'b0 || field_a !== 12'hA65) begin
            n_err++; $display("FAIL err_default: got e=%b f=%h want 0/a65", err_a, field_a);
        end
        tick();
        n_vec++;
        if (err_e !== 1'b0 || valid_e !== 1'b0) begin
            n_err++; $display("FAIL err_single: got e=%b v=%b want 0/0", err_e, valid_e);
        end
        set_off(5, 9'd100);
        client_req = 8'h20;
        tick();
        client_req = 8'h00;
        n_vec++;
        if (valid_e !== 1'b1 || field_e !== 12'hA64 || err_e !== 1'b0) begin
            n_err++; $display("FAIL err_legal: got v=%b f=%h e=%b want 1/a64/0", valid_e, field_e, err_e);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_off(2, 9'h033);
        client_req   = 8'h0C;
        egress_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (gnt_a !== 8'h00) begin
            n_err++; $display("FAIL mid_gnt_rst: got %h want 00", gnt_a);
        end
        tick();
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL mid_valid: got v=%b want 0", valid_a);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (gnt_a !== 8'h04) begin
            n_err++; $display("FAIL mid_first_gnt: got %h want 04", gnt_a);
        end
        tick();
        client_req = 8'h00;
        n_vec++;
        if (valid_a !== 1'b1 || field_a !== 12'h433) begin
            n_err++; $display("FAIL mid_field: got v=%b f=%h want 1/433", valid_a, field_a);
        end
        egress_ready = 1'b1;
        tick();
    endtask

`ifdef AH_ENCODER_CNT_EN
    task automatic test_counters();
        reset_dut();
        set_off(0, 9'h001);
        client_req   = 8'h01;
        egress_ready = 1'b1;
        tick();
        repeat (70000) tick();
        n_vec++;
        if (pkt_cnt_a !== 16'd4464) begin
            n_err++; $display("FAIL pkt_cnt: got %0d want 4464", pkt_cnt_a);
        end
        reset_dut();
        set_off(5, 9'd101);
        client_req = 8'h20;
        repeat (300) tick();
        client_req = 8'h00;
        repeat (3) tick();
        n_vec++;
        if (err_cnt_e !== 8'd255) begin
            n_err++; $display("FAIL err_cnt: got %0d want 255", err_cnt_e);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        client_req    = 8'h00;
        client_offset = '0;
        egress_ready  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enc_err();
        test_reset_mid();
`ifdef AH_ENCODER_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
